// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM states and
// elaboration-time sizing helpers.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_nch(input int width, input int chunk);
    return (chunk > 0) ? width / chunk : 0;
  endfunction

  // A single-chunk operation still needs a one-bit index register.
  function automatic int calc_idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from per-bit full-adder cells.
// Also reports the carry into its MSB so the caller can derive overflow.
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// with a registered carry between chunks and valid/ready on both sides.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int NCH = calc_nch(WIDTH, CHUNK);
  localparam int IW  = calc_idx_width(NCH);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid holds until accepted.
  state_e           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_next;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [CHUNK-1:0] csum;
  logic             ccout;
  logic             ccmsb;
  logic             last;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .sum  (csum),
    .cout (ccout),
    .cmsb (ccmsb)
  );

  // Operands shift right each cycle; results enter the accumulator from the
  // top so that after NCH steps chunk 0 has reached the LSBs.
  if (CHUNK == WIDTH) begin : g_acc_full
    assign acc_next = csum;
  end else begin : g_acc_shift
    assign acc_next = {csum, acc_q[WIDTH-1:CHUNK]};
  end

  assign last        = (idx_q == IW'(NCH - 1));
  assign in_ready_o  = (state == ST_IDLE);
  assign busy_o      = (state == ST_RUN);
  assign out_valid_o = (state == ST_DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_o   <= '0;
      cout_o  <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i | cin_i;
            idx_q   <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= ccout;
          acc_q   <= acc_next;
          idx_q   <= idx_q + IW'(1);
          if (last) begin
            sum_o  <= acc_next;
            cout_o <= ccout;
            ovf_o  <= ccout ^ ccmsb;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: directed cases on WIDTH=8/CHUNK=2, plus random
// sweeps over CHUNK=8, CHUNK=1 and WIDTH=32/CHUNK=4 against an arithmetic model.
module tb_seq_chunk_adder;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared 8-bit stimulus ----------------
  logic       in_valid = 1'b0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       rdy0, vld0, co0, ov0, bsy0;
  logic       rdy1, vld1, co1, ov1, bsy1;
  logic       rdy2, vld2, co2, ov2, bsy2;
  logic [7:0] sum0, sum1, sum2;

  // ---------------- 32-bit stimulus ----------------
  logic        in_valid32 = 1'b0;
  logic        cin32 = 1'b0;
  logic        sub32 = 1'b0;
  logic        out_ready32 = 1'b1;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        rdy32, vld32, co32, ov32, bsy32;
  logic [31:0] sum32;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .out_valid_o(vld0),
    .out_ready_i(out_ready), .sum_o(sum0), .cout_o(co0), .ovf_o(ov0), .busy_o(bsy0)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_c8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .out_valid_o(vld1),
    .out_ready_i(out_ready), .sum_o(sum1), .cout_o(co1), .ovf_o(ov1), .busy_o(bsy1)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_c1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy2),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .out_valid_o(vld2),
    .out_ready_i(out_ready), .sum_o(sum2), .cout_o(co2), .ovf_o(ov2), .busy_o(bsy2)
  );

  seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) dut_w32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid32), .in_ready_o(rdy32),
    .a_i(a32), .b_i(b32), .cin_i(cin32), .sub_i(sub32), .out_valid_o(vld32),
    .out_ready_i(out_ready32), .sum_o(sum32), .cout_o(co32), .ovf_o(ov32), .busy_o(bsy32)
  );

  // ---------------- reference model ----------------
  // Unsigned result modulo 2^w, carry/no-borrow flag, and signed range check.
  function automatic void model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                input logic mcin, input logic msub,
                                output logic [31:0] s, output logic c, output logic v);
    longint mask, ua, ub, full, sa, sb, sres, half;
    mask = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    ua = longint'(ma) & mask;
    ub = longint'(mb) & mask;
    if (msub) begin
      full = ua - ub;
      c = (ua >= ub);
    end else begin
      full = ua + ub + longint'(mcin);
      c = ((full >>> w) & 1) != 0;
    end
    s = 32'(full & mask);
    sa = (ua >= half) ? ua - (64'sd1 <<< w) : ua;
    sb = (ub >= half) ? ub - (64'sd1 <<< w) : ub;
    sres = msub ? sa - sb : sa + sb + longint'(mcin);
    v = (sres < -half) || (sres >= half);
  endfunction

  // ---------------- driver ----------------
  // Issues one operation to the 8-bit instances and returns cycles until
  // dut.out_valid_o rises (40 means it never did).
  task automatic do_txn8(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                         input logic tsub, output int lat);
    int t;
    t = 0;
    while (!rdy0 && t < 40) begin @(negedge clk); t++; end
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!vld0 && lat < 40) begin @(negedge clk); lat++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sum0 !== 8'h00) begin errors++; $display("FAIL reset_sum: got %0h expected 0", sum0); end
    checks++; if (co0 !== 1'b0)   begin errors++; $display("FAIL reset_cout: got %0b expected 0", co0); end
    checks++; if (ov0 !== 1'b0)   begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ov0); end
    checks++; if (vld0 !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %0b expected 0", vld0); end
    checks++; if (bsy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %0b expected 0", bsy0); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %0b expected 1", rdy0); end
  endtask

  task automatic test_directed();
    logic [7:0] da [4] = '{8'h7F, 8'hFF, 8'h05, 8'h80};
    logic [7:0] db [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
    logic       dc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       ds [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [4] = '{8'h80, 8'h01, 8'hFE, 8'h7F};
    logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       ev [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_txn8(da[i], db[i], dc[i], ds[i], lat);
      checks++; if (lat !== 4)      begin errors++; $display("FAIL dir%0d_latency: got %0d expected 4", i, lat); end
      checks++; if (sum0 !== es[i]) begin errors++; $display("FAIL dir%0d_sum: got %0h expected %0h", i, sum0, es[i]); end
      checks++; if (co0 !== ec[i])  begin errors++; $display("FAIL dir%0d_cout: got %0b expected %0b", i, co0, ec[i]); end
      checks++; if (ov0 !== ev[i])  begin errors++; $display("FAIL dir%0d_ovf: got %0b expected %0b", i, ov0, ev[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    do_txn8(8'h12, 8'h34, 1'b0, 1'b0, lat);
    a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (vld0 !== 1'b1)  begin errors++; $display("FAIL bp_valid%0d: got %0b expected 1", i, vld0); end
      checks++; if (rdy0 !== 1'b0)  begin errors++; $display("FAIL bp_ready%0d: got %0b expected 0", i, rdy0); end
      checks++; if (sum0 !== 8'h46) begin errors++; $display("FAIL bp_sum%0d: got %0h expected 46", i, sum0); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_exit_ready: got %0b expected 1", rdy0); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL bp_exit_valid: got %0b expected 0", vld0); end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!vld0 && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (lat !== 4)      begin errors++; $display("FAIL bp_next_latency: got %0d expected 4", lat); end
    checks++; if (sum0 !== 8'h77) begin errors++; $display("FAIL bp_next_sum: got %0h expected 77", sum0); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen;
    out_ready = 1'b1;
    while (!rdy0) @(negedge clk);
    a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (sum0 !== 8'h00) begin errors++; $display("FAIL abort_sum: got %0h expected 0", sum0); end
    checks++; if (bsy0 !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %0b expected 0", bsy0); end
    checks++; if (vld0 !== 1'b0)  begin errors++; $display("FAIL abort_valid: got %0b expected 0", vld0); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (vld0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %0b expected 0", seen); end
    do_txn8(8'h10, 8'h20, 1'b0, 1'b0, lat);
    checks++; if (sum0 !== 8'h30) begin errors++; $display("FAIL abort_next_sum: got %0h expected 30", sum0); end
    checks++; if (lat !== 4)      begin errors++; $display("FAIL abort_next_latency: got %0d expected 4", lat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acc_cyc [$];
    out_ready = 1'b1;
    while (!rdy0) @(negedge clk);
    a = 8'h21; b = 8'h43; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 26; cyc++) begin
      if (rdy0) acc_cyc.push_back(cyc);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (acc_cyc.size() !== 5) begin errors++; $display("FAIL b2b_accepts: got %0d expected 5", acc_cyc.size()); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
        errors++; $display("FAIL b2b_spacing%0d: got %0d expected 6", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  task automatic test_random8();
    int nch_exp [3] = '{4, 1, 8};
    logic [31:0] es;
    logic ec, ev;
    logic [2:0] done, vld_v;
    logic [7:0] sm [3];
    logic [2:0] cov, ovv;
    int t;
    out_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      t = 0;
      while (!(rdy0 && rdy1 && rdy2) && t < 40) begin @(negedge clk); t++; end
      checks++; if (!(rdy0 && rdy1 && rdy2)) begin errors++; $display("FAIL rnd8_ready_timeout: got %0b%0b%0b expected 111", rdy2, rdy1, rdy0); end
      a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      model(8, {24'd0, a}, {24'd0, b}, cin, sub, es, ec, ev);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      done = '0;
      for (int cyc = 0; cyc < 20 && done != 3'b111; cyc++) begin
        vld_v = {vld2, vld1, vld0};
        sm[0] = sum0; sm[1] = sum1; sm[2] = sum2;
        cov = {co2, co1, co0}; ovv = {ov2, ov1, ov0};
        for (int k = 0; k < 3; k++) begin
          if (!done[k] && vld_v[k]) begin
            done[k] = 1'b1;
            checks++; if (sm[k] !== es[7:0]) begin errors++; $display("FAIL rnd8_sum inst%0d: got %0h expected %0h", k, sm[k], es[7:0]); end
            checks++; if (cov[k] !== ec)     begin errors++; $display("FAIL rnd8_cout inst%0d: got %0b expected %0b", k, cov[k], ec); end
            checks++; if (ovv[k] !== ev)     begin errors++; $display("FAIL rnd8_ovf inst%0d: got %0b expected %0b", k, ovv[k], ev); end
            checks++; if (cyc !== nch_exp[k]) begin errors++; $display("FAIL rnd8_latency inst%0d: got %0d expected %0d", k, cyc, nch_exp[k]); end
          end
        end
        if (done != 3'b111) @(negedge clk);
      end
      checks++; if (done !== 3'b111) begin errors++; $display("FAIL rnd8_valid_timeout: got %0b expected 111", done); end
    end
    @(negedge clk);
  endtask

  task automatic test_random32();
    logic [31:0] es;
    logic ec, ev;
    int lat, t;
    out_ready32 = 1'b1;
    for (int it = 0; it < 30; it++) begin
      t = 0;
      while (!rdy32 && t < 40) begin @(negedge clk); t++; end
      a32 = $urandom; b32 = $urandom;
      if (it == 0) begin a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; end
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      model(32, a32, b32, cin32, sub32, es, ec, ev);
      in_valid32 = 1'b1;
      @(negedge clk);
      in_valid32 = 1'b0;
      lat = 0;
      while (!vld32 && lat < 40) begin @(negedge clk); lat++; end
      checks++; if (lat !== 8)     begin errors++; $display("FAIL rnd32_latency: got %0d expected 8", lat); end
      checks++; if (sum32 !== es)  begin errors++; $display("FAIL rnd32_sum: got %0h expected %0h", sum32, es); end
      checks++; if (co32 !== ec)   begin errors++; $display("FAIL rnd32_cout: got %0b expected %0b", co32, ec); end
      checks++; if (ov32 !== ev)   begin errors++; $display("FAIL rnd32_ovf: got %0b expected %0b", ov32, ev); end
      @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random8();
    test_random32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
